// File: rtl/scandoubler_rotate_memport.sv
`default_nettype none
// scandoubler_rotate_memport: arbitrates 16-word write bursts and 8-word read bursts onto one
// SDRAM word port; the cornerturn is done by swapping row/column in the write address.
module scandoubler_rotate_memport #(
  parameter int ROW_BITS = 10,
  parameter int COL_BITS = 10,
  parameter int ADDR_W   = 21
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                vidin_req,
  input  logic                vidin_frame,
  input  logic [ROW_BITS-1:0] vidin_row,
  input  logic [COL_BITS-1:0] vidin_col,
  input  logic [15:0]         vidin_d,
  output logic                vidin_ack,
  input  logic                vidout_req,
  input  logic                vidout_frame,
  input  logic [ROW_BITS-1:0] vidout_row,
  input  logic [COL_BITS-1:0] vidout_col,
  output logic [15:0]         vidout_d,
  output logic                vidout_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [15:0]         mem_rdata,
  input  logic                mem_rvalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSETTLE = 3'd1,
    WRITE   = 3'd2,
    RISSUE  = 3'd3,
    RDRAIN  = 3'd4
  } state_t;

  state_t              state, state_next;
  logic                settle, settle_next;
  logic                cool, cool_next;
  logic [3:0]          wcnt, wcnt_next;
  logic [3:0]          icnt, icnt_next;
  logic [3:0]          rcnt, rcnt_next;
  logic                base_frame, base_frame_next;
  logic [ROW_BITS-1:0] base_row, base_row_next;
  logic [COL_BITS-1:0] base_col, base_col_next;
  logic                rd_take;

  // Returns are only meaningful while a read burst is open; anything else is stale.
  assign rd_take = ((state == RISSUE) || (state == RDRAIN)) && mem_rvalid;

  always_comb begin
    state_next      = state;
    settle_next     = settle;
    cool_next       = cool;
    wcnt_next       = wcnt;
    icnt_next       = icnt;
    rcnt_next       = rcnt;
    base_frame_next = base_frame;
    base_row_next   = base_row;
    base_col_next   = base_col;
    vidin_ack       = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    vidout_ack      = rd_take && vidout_req;
    vidout_d        = (rd_take && vidout_req) ? mem_rdata : 16'h0000;

    if (rd_take) begin
      rcnt_next = rcnt + 4'd1;
    end

    case (state)
      IDLE: begin
        // One dead cycle after a read lets the upstream column settle before arbitration.
        if (cool) begin
          cool_next = 1'b0;
        end else if (vidin_req) begin
          state_next  = WSETTLE;
          settle_next = 1'b0;
        end else if (vidout_req) begin
          state_next      = RISSUE;
          base_frame_next = vidout_frame;
          base_row_next   = vidout_row;
          base_col_next   = vidout_col;
          icnt_next       = 4'd0;
          rcnt_next       = 4'd0;
        end
      end
      WSETTLE: begin
        if (settle) begin
          state_next  = WRITE;
          settle_next = 1'b0;
        end else begin
          settle_next = 1'b1;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vidin_frame, vidin_col, vidin_row};
        mem_wdata = vidin_d;
        if (mem_ack) begin
          vidin_ack   = 1'b1;
          wcnt_next   = wcnt + 4'd1;
          settle_next = 1'b0;
          state_next  = (wcnt == 4'hF) ? IDLE : WSETTLE;
        end
      end
      RISSUE: begin
        mem_req  = 1'b1;
        mem_addr = {base_frame, base_row, base_col + COL_BITS'(icnt)};
        if (mem_ack) begin
          icnt_next = icnt + 4'd1;
          if (icnt == 4'd7) begin
            state_next = RDRAIN;
          end
        end
      end
      RDRAIN: begin
        if (rcnt_next == 4'd8) begin
          state_next = IDLE;
          cool_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle     <= 1'b0;
      cool       <= 1'b0;
      wcnt       <= 4'd0;
      icnt       <= 4'd0;
      rcnt       <= 4'd0;
      base_frame <= 1'b0;
      base_row   <= '0;
      base_col   <= '0;
    end else begin
      state      <= state_next;
      settle     <= settle_next;
      cool       <= cool_next;
      wcnt       <= wcnt_next;
      icnt       <= icnt_next;
      rcnt       <= rcnt_next;
      base_frame <= base_frame_next;
      base_row   <= base_row_next;
      base_col   <= base_col_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scandoubler_rotate_memport.sv
`default_nettype none
// Directed bench for scandoubler_rotate_memport with an upstream writer, a read sink and
// an in-order SDRAM port model with programmable read latency and write-ack stall.
module tb_scandoubler_rotate_memport;
  localparam int ROW_BITS = 10;
  localparam int COL_BITS = 10;
  localparam int ADDR_W   = 21;

  logic                clk_sys = 1'b0;
  logic                reset_n = 1'b0;
  logic                vidin_req = 1'b0;
  logic                vidin_frame = 1'b0;
  logic [ROW_BITS-1:0] vidin_row = '0;
  logic [COL_BITS-1:0] vidin_col = '0;
  logic [15:0]         vidin_d = '0;
  logic                vidin_ack;
  logic                vidout_req = 1'b0;
  logic                vidout_frame = 1'b0;
  logic [ROW_BITS-1:0] vidout_row = '0;
  logic [COL_BITS-1:0] vidout_col = '0;
  logic [15:0]         vidout_d;
  logic                vidout_ack;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [15:0]         mem_wdata;
  logic                mem_ack = 1'b0;
  logic [15:0]         mem_rdata = '0;
  logic                mem_rvalid = 1'b0;

  always #5 clk_sys = ~clk_sys;

  scandoubler_rotate_memport #(
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .ADDR_W(ADDR_W)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic              w_active = 1'b0;
  logic              w_frame = 1'b0;
  logic [9:0]        w_row = '0;
  logic [9:0]        w_col0 = '0;
  int                w_cnt = 0;
  int                w_last = 0;
  logic              w_upd = 1'b0;
  int                w_stall = 0;
  int                w_stall_seen = 0;
  logic [ADDR_W-1:0] w_addr_log [16];

  logic              r_frame = 1'b0;
  logic [9:0]        r_row = '0;
  logic [9:0]        r_col0 = '0;
  int                r_issued = 0;
  int                r_returned = 0;
  int                r_acks = 0;
  int                r_lat = 1;
  int                r_drop_after = 8;
  int                r_first_ack = -1;
  logic              r_drop_pend = 1'b0;
  logic [ADDR_W-1:0] r_addr_log [8];
  int                rq_cyc [$];
  logic [15:0]       rq_dat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wgen(input int k, input logic [9:0] row);
    return 16'h8000 | 16'(k << 4) | 16'(row[3:0]);
  endfunction

  function automatic logic [15:0] rgen(input int i);
    return 16'hA5C0 + 16'(i * 'h111);
  endfunction

  task automatic outputs_zero(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
    check({tag, "_vidin_ack"},  32'(vidin_ack),  32'd0);
    check({tag, "_vidout_ack"}, 32'(vidout_ack), 32'd0);
    check({tag, "_vidout_d"},   32'(vidout_d),   32'd0);
  endtask

  task automatic start_write(input logic f, input logic [9:0] row, input logic [9:0] col0,
                             input int stall);
    w_active = 1'b1; w_frame = f; w_row = row; w_col0 = col0;
    w_cnt = 0; w_last = 0; w_upd = 1'b0; w_stall = stall; w_stall_seen = 0;
    vidin_frame = f; vidin_row = row; vidin_col = col0; vidin_d = wgen(0, row);
    vidin_req = 1'b1;
  endtask

  task automatic start_read(input logic f, input logic [9:0] row, input logic [9:0] col0,
                            input int lat, input int drop);
    r_frame = f; r_row = row; r_col0 = col0;
    r_issued = 0; r_returned = 0; r_acks = 0; r_lat = lat; r_drop_after = drop;
    r_first_ack = -1; r_drop_pend = 1'b0;
    vidout_frame = f; vidout_row = row; vidout_col = col0;
    vidout_req = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, observe 1 ns later.
  task automatic step();
    logic rv, vr, wr_cmd, rd_cmd;
    @(negedge clk_sys);
    cyc++;
    if (w_upd) begin
      w_upd = 1'b0;
      if (w_cnt >= 16) vidin_req = 1'b0;
      else begin
        vidin_col = w_col0 + 10'(w_cnt);
        vidin_d   = wgen(w_cnt, w_row);
      end
    end
    if (r_drop_pend) begin
      vidout_req  = 1'b0;
      r_drop_pend = 1'b0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    if (rq_cyc.size() > 0 && rq_cyc[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq_dat.pop_front();
      void'(rq_cyc.pop_front());
    end
    mem_ack = (w_stall == 0);
    #1;
    rv = mem_rvalid;
    vr = vidout_req;
    wr_cmd = mem_req && mem_we;
    rd_cmd = mem_req && !mem_we;
    if (wr_cmd) begin
      check("wr_addr", 32'(mem_addr), 32'({w_frame, w_col0 + 10'(w_cnt), w_row}));
      check("wr_data", 32'(mem_wdata), 32'(wgen(w_cnt, w_row)));
      if (!mem_ack) begin
        check("stall_no_vidin_ack", 32'(vidin_ack), 32'd0);
        w_stall--;
        w_stall_seen++;
      end else begin
        check("vidin_ack", 32'(vidin_ack), 32'd1);
        if (w_cnt > 0) check("ack_gap_ge3", 32'((cyc - w_last) >= 3), 32'd1);
        if (w_cnt < 16) w_addr_log[w_cnt] = mem_addr;
        w_last = cyc;
        w_cnt++;
        w_upd = 1'b1;
      end
    end else begin
      check("no_vidin_ack", 32'(vidin_ack), 32'd0);
    end
    if (rd_cmd && mem_ack) begin
      check("rd_addr", 32'(mem_addr), 32'({r_frame, r_row, r_col0 + 10'(r_issued)}));
      check("rd_not_in_write", 32'(w_active && (w_cnt < 16)), 32'd0);
      if (r_issued < 8) r_addr_log[r_issued] = mem_addr;
      if (r_issued == 0) r_first_ack = cyc;
      rq_cyc.push_back(cyc + r_lat);
      rq_dat.push_back(rgen(r_issued));
      r_issued++;
    end
    if (rv) r_returned++;
    if (rv && vr) begin
      check("vidout_ack", 32'(vidout_ack), 32'd1);
      check("vidout_d", 32'(vidout_d), 32'(rgen(r_returned - 1)));
      r_acks++;
      if (r_acks == r_drop_after) r_drop_pend = 1'b1;
    end else begin
      check("no_vidout_ack", 32'(vidout_ack), 32'd0);
    end
  endtask

  task automatic idle_checks(input string tag);
    repeat (3) begin
      step();
      check(tag, 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_sys);
    #1;
    outputs_zero("rst");

    // Enter RISSUE with mem_ack withheld, then reset mid-burst
    @(negedge clk_sys);
    reset_n = 1'b1;
    start_read(1'b1, 10'd2, 10'h100, 3, 8);
    mem_ack = 1'b0;
    @(negedge clk_sys);
    #1;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    check("pre_rst_addr", 32'(mem_addr), 32'h0010_0900);
    reset_n = 1'b0;
    #1;
    outputs_zero("async_rst");
    @(negedge clk_sys);
    #1;
    outputs_zero("rst_next");

    // Release with a stale return pending; then wrap-around read, latency 3
    @(negedge clk_sys);
    reset_n = 1'b1;
    start_read(1'b0, 10'd7, 10'h3FC, 3, 8);
    mem_ack    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    #1;
    check("stale_rvalid_no_ack", 32'(vidout_ack), 32'd0);
    check("stale_rvalid_no_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 100 && !(r_returned == 8 && rq_cyc.size() == 0); i++) step();
    check("wrap_returns", 32'(r_returned), 32'd8);
    check("wrap_acks", 32'(r_acks), 32'd8);
    check("wrap_issued", 32'(r_issued), 32'd8);
    check("wrap_addr0", 32'(r_addr_log[0]), 32'h0000_1FFC);
    check("wrap_addr3", 32'(r_addr_log[3]), 32'h0000_1FFF);
    check("wrap_addr4", 32'(r_addr_log[4]), 32'h0000_1C00);
    check("wrap_addr7", 32'(r_addr_log[7]), 32'h0000_1C03);
    idle_checks("wrap_idle_after");

    // Write burst, row 5, cols 0x020..0x02F, frame 1, immediate ack
    start_write(1'b1, 10'h005, 10'h020, 0);
    for (int i = 0; i < 200 && w_cnt < 16; i++) step();
    check("wr_count", 32'(w_cnt), 32'd16);
    check("wr_addr_word0", 32'(w_addr_log[0]), 32'h0010_8005);
    check("wr_addr_word15", 32'(w_addr_log[15]), 32'h0010_BC05);
    idle_checks("wr_idle_after");

    // Simultaneous requests: write burst must complete before any read command
    start_write(1'b0, 10'h0AA, 10'h140, 0);
    start_read(1'b1, 10'h033, 10'h200, 2, 8);
    for (int i = 0; i < 300 && !(w_cnt == 16 && r_returned == 8 && rq_cyc.size() == 0); i++)
      step();
    check("both_wr_count", 32'(w_cnt), 32'd16);
    check("both_rd_acks", 32'(r_acks), 32'd8);
    check("both_rd_after_wr", 32'(r_first_ack > w_last), 32'd1);
    idle_checks("both_idle_after");

    // Read fetch ends after the 3rd returned word
    start_read(1'b1, 10'd1, 10'h010, 2, 3);
    for (int i = 0; i < 100 && !(r_returned == 8 && rq_cyc.size() == 0); i++) step();
    check("drop_acks", 32'(r_acks), 32'd3);
    check("drop_returns", 32'(r_returned), 32'd8);
    check("drop_issued", 32'(r_issued), 32'd8);
    idle_checks("drop_idle_after");

    // Write with mem_ack withheld for 10 cycles on the first word
    start_write(1'b0, 10'h003, 10'h1F0, 10);
    for (int i = 0; i < 300 && w_cnt < 16; i++) step();
    check("stall_cycles", 32'(w_stall_seen), 32'd10);
    check("stall_wr_count", 32'(w_cnt), 32'd16);
    check("stall_addr_word0", 32'(w_addr_log[0]), 32'h0007_C003);
    idle_checks("stall_idle_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scandoubler_rotate_memport.md
Name: scandoubler_rotate_memport

Overview:
- Memory-side stage directly downstream of the rotating scandoubler.
- Services its two burst streams against a single word-oriented SDRAM controller port:
  - writes: 16-word bursts of incoming video.
  - reads: 8-word bursts feeding the output linebuffer.
- Performs the cornerturn by address mapping: an input pixel at (row, col) is stored at output-row = col, output-col = row.
- Double-buffered by the frame bit.

Parameters:
- ROW_BITS, 10, width of row coordinates.
- COL_BITS, 10, width of column coordinates.
- ADDR_W, 21, memory word address width; must equal 1+ROW_BITS+COL_BITS.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vidin_req  in  1  write burst pending; high until the 16th word is acked.
- vidin_frame  in  1  frame bit for writes.
- vidin_row  in  ROW_BITS  input row of the current burst.
- vidin_col  in  COL_BITS  input column of the current word (low 4 bits track the word).
- vidin_d  in  16  RGB565 word.
- vidin_ack  out  1  one-cycle pulse per word consumed.
- vidout_req  in  1  read request; high while the row still needs data.
- vidout_frame  in  1  frame bit for reads.
- vidout_row  in  ROW_BITS  output row.
- vidout_col  in  COL_BITS  next output column required.
- vidout_d  out  16  read data.
- vidout_ack  out  1  vidout_d valid this cycle.
- mem_req  out  1  word command valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  {frame, out_row, out_col}.
- mem_wdata  out  16  write data.
- mem_ack  in  1  command accepted this cycle.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  read data valid; returns in order, any latency ≥1.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, every output 0.
- FSM states: IDLE, WSETTLE, WRITE, RISSUE, RDRAIN.
- IDLE:
  - vidin_req → WSETTLE. Writes have priority, because the upstream row buffer holds only 2 bursts.
  - Otherwise vidout_req → RISSUE.
- IDLE → RISSUE capture:
  - Latch base = {vidout_frame, vidout_row, vidout_col}.
  - Clear issue count and return count.
- WSETTLE:
  - 2-cycle wait for upstream vidin_d/vidin_col, which update 2 edges after req rise or after an ack. Then → WRITE.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_wdata=vidin_d, mem_addr={vidin_frame, vidin_col, vidin_row}.
  - On mem_ack: pulse vidin_ack for 1 cycle; increment the 4-bit word count.
  - Count wraps 15→0: burst done, → IDLE.
  - Otherwise → WSETTLE.
- RISSUE:
  - mem_req=1, mem_we=0, mem_addr = base with col = base_col + issue count; low COL_BITS wrap modulo 2^COL_BITS.
  - Each mem_ack increments the issue count. After the 8th ack → RDRAIN.
- mem_rvalid is accepted in RISSUE and RDRAIN:
  - Each mem_rvalid increments the return count.
  - If vidout_req is high, pass mem_rdata to vidout_d and pulse vidout_ack, same cycle (combinational valid path, registered data allowed).
  - If vidout_req is low (fetch ended mid-burst), discard the word with no ack. The burst still completes so the controller stays in sync.
- RDRAIN → IDLE when the return count reaches 8. One idle cycle follows before a new arbitration, which lets upstream vidout_col settle.
- Write priority is checked only in IDLE; bursts are never preempted.
- Worst-case read latency is therefore one write burst plus one read burst.
- vidin_req falling mid-write is a protocol error: finish the 16 words anyway.
- mem_req stays high until mem_ack; address and data are held stable while mem_req=1 and mem_ack=0.
- Frame bits are captured per word for writes and per burst for reads; frame toggles mid-burst have no effect on a burst in progress.
- Asserting reset_n low mid-burst aborts immediately. Outstanding read returns after release are ignored: the return count is 0 and the state is IDLE.

Test Plan:
- Reset mid-RISSUE → all outputs 0 next cycle; the first post-release mem_rvalid produces no vidout_ack.
- Write burst, vidin_row=5, cols 0x020..0x02F, frame 1, mem_ack immediate → exactly 16 vidin_ack pulses, each ≥3 cycles apart. Address of word 0 = {1, 0x020, 0x005}, word 15 = {1, 0x02F, 0x005}.
- Read, vidout_row=7, vidout_col=0x3FC, frame 0, rdata latency 3 → addresses cols 0x3FC..0x3FF then 0x000..0x003 (wrap); 8 vidout_ack with data in order.
- vidin_req and vidout_req rise the same cycle → full write burst first, then the read burst. No interleaving of mem_we within a burst.
- vidout_req drops after the 3rd returned word → exactly 3 vidout_ack; remaining 5 words absorbed; IDLE after the 8th mem_rvalid.
- mem_ack held low 10 cycles during WRITE → mem_addr/mem_wdata stable, no vidin_ack until mem_ack.
